// File: rtl/mm_param.sv
`default_nettype none
// ============================================================================
// Module   : mm_param
// Purpose  : Sequential matrix multiplier C = A*B or C = C + A*B over
//            combinational A/B/C memories, one element access per cycle.
// Revision : 1.0  initial release
// ============================================================================
module mm_param #(
    parameter int DW     = 20,
    parameter int AW     = 20,
    parameter int OW     = 2 * DW,
    parameter int SIGNED = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          acc_mode,
    input  logic [AW-1:0] dim_m,
    input  logic [AW-1:0] dim_k,
    input  logic [AW-1:0] dim_n,
    input  logic [DW-1:0] read_data,
    input  logic [OW-1:0] c_read_data,
    output logic [AW-1:0] i,
    output logic [AW-1:0] j,
    output logic [1:0]    index,
    output logic          read,
    output logic          write,
    output logic [OW-1:0] write_data,
    output logic          busy,
    output logic          finish
);

    // ZERO is the single busy cycle spent when a dimension is 0.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ZERO = 3'd1,
        RDC  = 3'd2,
        RDA  = 3'd3,
        RDB  = 3'd4,
        WR   = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t        state;
    logic [AW-1:0] m_lat;
    logic [AW-1:0] k_lat;
    logic [AW-1:0] n_lat;
    logic          mode;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic [AW-1:0] kk;
    logic [DW-1:0] a_reg;
    logic [OW-1:0] acc;

    logic [OW-1:0] a_ext;
    logic [OW-1:0] b_ext;
    logic [OW-1:0] prod;
    logic [OW-1:0] sum;
    logic          dims_zero;
    logic          last_col;
    logic          last_row;
    logic          last_k;
    logic [AW-1:0] next_row;
    logic [AW-1:0] next_col;

    generate
        if (SIGNED != 0) begin : g_signed
            assign a_ext = {{(OW-DW){a_reg[DW-1]}}, a_reg};
            assign b_ext = {{(OW-DW){read_data[DW-1]}}, read_data};
        end else begin : g_unsigned
            assign a_ext = {{(OW-DW){1'b0}}, a_reg};
            assign b_ext = {{(OW-DW){1'b0}}, read_data};
        end
    endgenerate

    // Truncated OW-bit product of the extended operands is exact mod 2^OW.
    assign prod      = a_ext * b_ext;
    assign sum       = acc + prod;

    assign dims_zero = (dim_m == '0) || (dim_k == '0) || (dim_n == '0);
    assign last_col  = (col == n_lat - AW'(1));
    assign last_row  = (row == m_lat - AW'(1));
    assign last_k    = (kk == k_lat - AW'(1));
    assign next_row  = last_col ? row + AW'(1) : row;
    assign next_col  = last_col ? '0 : col + AW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            m_lat      <= '0;
            k_lat      <= '0;
            n_lat      <= '0;
            mode       <= 1'b0;
            row        <= '0;
            col        <= '0;
            kk         <= '0;
            a_reg      <= '0;
            acc        <= '0;
            i          <= '0;
            j          <= '0;
            index      <= 2'd0;
            read       <= 1'b0;
            write      <= 1'b0;
            write_data <= '0;
            busy       <= 1'b0;
            finish     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_lat <= dim_m;
                        k_lat <= dim_k;
                        n_lat <= dim_n;
                        mode  <= acc_mode;
                        row   <= '0;
                        col   <= '0;
                        kk    <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        if (dims_zero) begin
                            state <= ZERO;
                        end else begin
                            read  <= 1'b1;
                            i     <= '0;
                            j     <= '0;
                            index <= acc_mode ? 2'd2 : 2'd0;
                            state <= acc_mode ? RDC : RDA;
                        end
                    end
                end
                ZERO: begin
                    busy   <= 1'b0;
                    finish <= 1'b1;
                    state  <= DONE;
                end
                RDC: begin
                    acc   <= c_read_data;
                    index <= 2'd0;
                    i     <= row;
                    j     <= '0;
                    state <= RDA;
                end
                RDA: begin
                    a_reg <= read_data;
                    index <= 2'd1;
                    i     <= kk;
                    j     <= col;
                    state <= RDB;
                end
                RDB: begin
                    acc <= sum;
                    if (last_k) begin
                        read       <= 1'b0;
                        write      <= 1'b1;
                        index      <= 2'd2;
                        i          <= row;
                        j          <= col;
                        write_data <= sum;
                        state      <= WR;
                    end else begin
                        kk    <= kk + AW'(1);
                        index <= 2'd0;
                        i     <= row;
                        j     <= kk + AW'(1);
                        state <= RDA;
                    end
                end
                WR: begin
                    write <= 1'b0;
                    kk    <= '0;
                    acc   <= '0;
                    if (last_col && last_row) begin
                        busy   <= 1'b0;
                        finish <= 1'b1;
                        index  <= 2'd0;
                        i      <= '0;
                        j      <= '0;
                        state  <= DONE;
                    end else begin
                        row   <= next_row;
                        col   <= next_col;
                        read  <= 1'b1;
                        i     <= next_row;
                        j     <= mode ? next_col : '0;
                        index <= mode ? 2'd2 : 2'd0;
                        state <= mode ? RDC : RDA;
                    end
                end
                DONE: begin
                    finish <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mm_param.md
MM_PARAM -- requirements
Module: mm_param

Interface
REQ-001 Parameter DW, default 20: width of A/B elements on read_data.
REQ-002 Parameter AW, default 20: width of i, j and the dimension inputs.
REQ-003 Parameter OW, default 2*DW: width of C elements and the accumulator; SHALL be >= 2*DW.
REQ-004 Parameter SIGNED, default 1: 1 means signed operands, 0 means unsigned.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  start request, sampled only in IDLE.
REQ-008 acc_mode  input  1  latched at start: 0 means C=A*B, 1 means C=C+A*B.
REQ-009 dim_m, dim_k, dim_n  input  AW each  A is MxK, B is KxN, C is MxN; latched at start.
REQ-010 read_data  input  DW  element of A or B addressed this cycle (combinational memory).
REQ-011 c_read_data  input  OW  element of C addressed this cycle (combinational memory).
REQ-012 i, j  output  AW each  row and column address of the current access.
REQ-013 index  output  2  matrix select: 0=A, 1=B, 2=C; 3 is never driven.
REQ-014 read, write  output  1 each  access strobes; never high together.
REQ-015 write_data  output  OW  C element written when write=1.
REQ-016 busy  output  1  high while an operation is in progress.
REQ-017 finish  output  1  one-cycle completion pulse.

Function
REQ-018 States: IDLE, RDC, RDA, RDB, WR, DONE; all outputs are registered.
REQ-019 IDLE: read=write=0, i=j=0, index=0, busy=0; start=1 latches dims and acc_mode and sets busy=1 next cycle.
REQ-020 Any latched dim equal to 0: go to DONE with no memory access; finish pulses on the 2nd cycle after start.
REQ-021 Elements are processed row-major, r=0..M-1 outer and c=0..N-1 inner; each begins with accumulator=0 (acc_mode=0) or RDC (acc_mode=1).
REQ-022 RDC: read=1, index=2, i=r, j=c; accumulator loads c_read_data at the clock edge.
REQ-023 RDA (k-th term): read=1, index=0, i=r, j=k; read_data is held in operand register a.
REQ-024 RDB: read=1, index=1, i=k, j=c; accumulator += ext(a)*ext(read_data). ext() is sign-extension to OW when SIGNED=1 and zero-extension otherwise.
REQ-025 All arithmetic is modulo 2^OW: wrap-around with no saturation and no overflow flag.
REQ-026 After RDB with k=K-1, go to WR; otherwise go to RDA with k+1.
REQ-027 WR: write=1, read=0, index=2, i=r, j=c, write_data=accumulator; then either the next element or DONE after (M-1,N-1).
REQ-028 Per-element latency: 2K+1 cycles (acc_mode=0) or 2K+2 cycles (acc_mode=1).
REQ-029 DONE: finish=1 and busy=0 for exactly one cycle, then IDLE; a new start is accepted from the following cycle.
REQ-030 start while busy or in DONE is ignored; dim and acc_mode changes mid-operation have no effect.
REQ-031 write_data holds its last written value outside WR.

Reset
REQ-032 reset=0 forces IDLE asynchronously, whatever the current state.
REQ-033 Reset values: i=j=0, index=0, read=write=0, write_data=0, busy=0, finish=0, accumulator=0, latched dims=0.
REQ-034 A reset during an operation abandons it: no further writes and no finish pulse.

Verification
REQ-035 M=2,K=3,N=2, A=[1 2 3;4 5 6], B=[7 8;9 10;11 12], acc_mode=0 -> writes C00=58, C01=64, C10=139, C11=154 in that order. Each write is 7 cycles apart. finish pulses once; busy spans 28 cycles.
REQ-036 Same operands, acc_mode=1, C preloaded with all 100 -> writes 158, 164, 239, 254 at 8-cycle spacing.
REQ-037 SIGNED=1, DW=20, M=K=N=1, A=-3, B=5 -> write_data=-15 (all ones above bit 3). With SIGNED=0 and A=0xFFFFD, B=5 -> 0x4FFFF1.
REQ-038 dim_k=0 with M=N=2 -> no read/write strobes; finish on the 2nd cycle after start.
REQ-039 Assert reset=0 during the 3rd RDA of a 2x3x2 run -> outputs at reset values immediately, no finish. A new start after reset release gives correct results.
REQ-040 start held high for an entire 1x1x1 run -> exactly one operation and one finish. A second operation starts the cycle after DONE returns to IDLE.
